// File: rtl/fifo_wr_arbiter_if.sv
// Producer-side handshake and FIFO write-port bundle for fifo_wr_arbiter.
// master = producers/FIFO environment, slave = the arbiter.
interface fifo_wr_arbiter_if #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 8
);
    localparam int ID_W = $clog2(NUM_REQ);

    logic [NUM_REQ-1:0]            req_valid;
    logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
    logic [NUM_REQ-1:0]            req_ready;
    logic                          fifo_full;
    logic                          fifo_wr;
    logic [DATA_WIDTH-1:0]         fifo_wdata;
    logic                          grant_valid;
    logic [ID_W-1:0]               grant_id;

    modport master (
        output req_valid, req_data, fifo_full,
        input  req_ready, fifo_wr, fifo_wdata, grant_valid, grant_id
    );

    modport slave (
        input  req_valid, req_data, fifo_full,
        output req_ready, fifo_wr, fifo_wdata, grant_valid, grant_id
    );
endinterface

// File: rtl/fifo_wr_arbiter.sv
// Round-robin burst arbiter sharing one FIFO write port among NUM_REQ producers.
// One IDLE arbitration cycle per grant, up to BURST_LEN beats per grant.
module fifo_wr_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 8,
    parameter int BURST_LEN  = 4
) (
    input logic              clk,
    input logic              rst,
    fifo_wr_arbiter_if.slave bus
);
    localparam int ID_W  = $clog2(NUM_REQ);
    localparam int CNT_W = $clog2(BURST_LEN) + 1;

    localparam logic [0:0] S_IDLE  = 1'b0;
    localparam logic [0:0] S_GRANT = 1'b1;

    logic [0:0]       r_state;
    logic [ID_W-1:0]  r_grant_id;
    logic [ID_W-1:0]  r_rr_ptr;
    logic [CNT_W-1:0] r_beat_cnt;

    logic             w_found;
    logic [ID_W-1:0]  w_winner;
    logic [ID_W-1:0]  w_next_ptr;
    logic             w_gvalid;
    logic             w_xfer;
    logic             w_last;

    // Walk from the highest offset down so the lowest offset from rr_ptr wins.
    always_comb begin
        w_found  = 1'b0;
        w_winner = r_rr_ptr;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (bus.req_valid[(int'(r_rr_ptr) + k) % NUM_REQ]) begin
                w_found  = 1'b1;
                w_winner = ID_W'((int'(r_rr_ptr) + k) % NUM_REQ);
            end
        end
    end

    assign w_gvalid   = bus.req_valid[r_grant_id];
    assign w_xfer     = (r_state == S_GRANT) && w_gvalid && !bus.fifo_full;
    assign w_last     = (r_beat_cnt == CNT_W'(BURST_LEN - 1));
    assign w_next_ptr = (r_grant_id == ID_W'(NUM_REQ - 1)) ? '0 : r_grant_id + ID_W'(1);

    for (genvar i = 0; i < NUM_REQ; i++) begin : g_ready
        assign bus.req_ready[i] = (r_state == S_GRANT) && (r_grant_id == ID_W'(i)) && !bus.fifo_full;
    end

    assign bus.fifo_wr     = w_xfer;
    assign bus.fifo_wdata  = w_xfer ? bus.req_data[r_grant_id*DATA_WIDTH +: DATA_WIDTH] : '0;
    assign bus.grant_valid = (r_state == S_GRANT);
    assign bus.grant_id    = r_grant_id;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= S_IDLE;
            r_grant_id <= '0;
            r_rr_ptr   <= '0;
            r_beat_cnt <= '0;
        end else if (r_state == S_IDLE) begin
            if (w_found) begin
                r_state    <= S_GRANT;
                r_grant_id <= w_winner;
                r_beat_cnt <= '0;
            end
        end else begin
            // A dropped valid ends the burst even while the FIFO is full.
            if (!w_gvalid) begin
                r_state  <= S_IDLE;
                r_rr_ptr <= w_next_ptr;
            end else if (w_xfer) begin
                r_beat_cnt <= r_beat_cnt + CNT_W'(1);
                if (w_last) begin
                    r_state  <= S_IDLE;
                    r_rr_ptr <= w_next_ptr;
                end
            end
        end
    end
endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Scoreboard bench for fifo_wr_arbiter: stimulus pushes expected writes,
// a negedge monitor pops and compares every FIFO write.
module tb_fifo_wr_arbiter;
    localparam int NR = 4;
    localparam int DW = 8;
    localparam int BL = 4;

    typedef struct packed {
        logic [1:0] id;
        logic [7:0] data;
    } beat_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    fifo_wr_arbiter_if #(.NUM_REQ(NR), .DATA_WIDTH(DW)) bus ();

    fifo_wr_arbiter #(.NUM_REQ(NR), .DATA_WIDTH(DW), .BURST_LEN(BL)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    beat_t   exp_q[$];
    int      checks = 0;
    int      errors = 0;
    int      cyc    = 0;
    int      wcnt   [NR];
    int      wstamp [NR][64];

    logic [7:0]    pdata [NR][16];
    int            pidx  [NR];
    int            plen  [NR];
    logic [NR-1:0] en;
    logic [NR-1:0] fire;
    logic [NR-1:0] s_ready;
    logic          s_wr, s_gv;
    logic [1:0]    s_gid;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: every write must match the head of the expected queue.
    always @(negedge clk) begin
        beat_t e;
        if (rst) begin
            checks++;
            if (bus.fifo_wr && bus.fifo_full) begin
                errors++;
                $display("FAIL wr_while_full: fifo_wr=1 with fifo_full=1 at cycle %0d", cyc);
            end
            if (bus.fifo_wr) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_write: id=%0d data=%02h, required no write", bus.grant_id, bus.fifo_wdata);
                end else begin
                    e = exp_q.pop_front();
                    if (e.id !== bus.grant_id || e.data !== bus.fifo_wdata) begin
                        errors++;
                        $display("FAIL write: got id=%0d data=%02h, required id=%0d data=%02h",
                                 bus.grant_id, bus.fifo_wdata, e.id, e.data);
                    end
                end
                if (wcnt[bus.grant_id] < 64) wstamp[bus.grant_id][wcnt[bus.grant_id]] = cyc;
                wcnt[bus.grant_id]++;
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %0h required %0h", nm, act, expv);
        end
    endtask

    task automatic push(input int id, input int d);
        beat_t e;
        e.id   = 2'(id);
        e.data = 8'(d);
        exp_q.push_back(e);
    endtask

    task automatic drive();
        for (int i = 0; i < NR; i++) begin
            bus.req_valid[i] = en[i] && (pidx[i] < plen[i]);
            bus.req_data[i*DW +: DW] = bus.req_valid[i] ? pdata[i][pidx[i]] : 8'h00;
        end
    endtask

    task automatic half_neg();
        @(negedge clk);
        fire    = bus.req_valid & bus.req_ready;
        s_wr    = bus.fifo_wr;
        s_ready = bus.req_ready;
        s_gv    = bus.grant_valid;
        s_gid   = bus.grant_id;
    endtask

    task automatic half_pos();
        @(posedge clk);
        #1;
        for (int i = 0; i < NR; i++)
            if (fire[i] && pidx[i] < plen[i]) pidx[i]++;
        drive();
    endtask

    task automatic step();
        half_neg();
        half_pos();
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;
        en  = '0;
        bus.fifo_full = 1'b0;
        for (int i = 0; i < NR; i++) begin
            plen[i] = 0;
            pidx[i] = 0;
        end
        drive();
        step();
        step();
    endtask

    task automatic load(input int p, input int base, input int n);
        for (int k = 0; k < n; k++) pdata[p][k] = 8'(base + k);
        plen[p] = n;
        pidx[p] = 0;
        en[p]   = 1'b1;
    endtask

    task automatic release_rst();
        drive();
        rst = 1'b1;
    endtask

    task automatic wait_drain(input string nm, input int max);
        for (int n = 0; n < max && exp_q.size() > 0; n++) step();
        chk(nm, exp_q.size(), 0);
    endtask

    initial begin
        int b0, b3, found;
        en = '0;
        bus.req_valid = '0;
        bus.req_data  = '0;
        bus.fifo_full = 1'b0;
        for (int i = 0; i < NR; i++) begin
            wcnt[i] = 0; plen[i] = 0; pidx[i] = 0;
        end

        // Reset with random inputs: every output held at 0.
        for (int t = 0; t < 3; t++) begin
            @(negedge clk);
            bus.req_valid = 4'($urandom);
            bus.req_data  = $urandom;
            bus.fifo_full = 1'($urandom);
            #1;
            chk("rst_fifo_wr", bus.fifo_wr, 0);
            chk("rst_req_ready", bus.req_ready, 0);
            chk("rst_fifo_wdata", bus.fifo_wdata, 0);
            chk("rst_grant_valid", bus.grant_valid, 0);
            chk("rst_grant_id", bus.grant_id, 0);
        end
        @(posedge clk);
        #1;
        bus.fifo_full = 1'b0;
        release_rst();
        for (int t = 0; t < 3; t++) begin
            step();
            chk("idle_no_wr", s_wr, 0);
            chk("idle_no_grant", s_gv, 0);
        end

        // Single producer 2: two full bursts separated by one idle cycle.
        do_reset();
        b0 = wcnt[2];
        load(2, 8'h10, 8);
        for (int k = 0; k < 8; k++) push(2, 8'h10 + k);
        release_rst();
        wait_drain("single_drain", 60);
        chk("single_burst1_span", wstamp[2][b0+3] - wstamp[2][b0], 3);
        chk("single_idle_gap", wstamp[2][b0+4] - wstamp[2][b0+3], 2);
        chk("single_burst2_span", wstamp[2][b0+7] - wstamp[2][b0+4], 3);

        // Full contention: order 0,1,2,3 twice, 8 beats each over 40 cycles.
        do_reset();
        b0 = wcnt[0];
        b3 = wcnt[3];
        for (int p = 0; p < NR; p++) load(p, p * 32, 8);
        for (int r = 0; r < 2; r++)
            for (int p = 0; p < NR; p++)
                for (int b = 0; b < BL; b++) push(p, p * 32 + r * 4 + b);
        release_rst();
        wait_drain("cont_drain", 100);
        chk("cont_span", wstamp[3][b3+7] - wstamp[0][b0], 38);
        chk("cont_p0_beats", wcnt[0] - b0, 8);
        chk("cont_p3_beats", wcnt[3] - b3, 8);

        // Back-pressure on producer 1 after its 2nd beat.
        do_reset();
        b0 = wcnt[1];
        load(1, 8'h40, 4);
        for (int k = 0; k < 4; k++) push(1, 8'h40 + k);
        release_rst();
        for (int n = 0; n < 20 && pidx[1] < 2; n++) step();
        chk("bp_reach_beat2", pidx[1], 2);
        bus.fifo_full = 1'b1;
        for (int t = 0; t < 3; t++) begin
            step();
            chk("bp_no_wr", s_wr, 0);
            chk("bp_ready1_low", s_ready, 0);
            chk("bp_grant_held", {s_gv, s_gid}, {1'b1, 2'd1});
        end
        bus.fifo_full = 1'b0;
        wait_drain("bp_drain", 20);
        chk("bp_stall_gap", wstamp[1][b0+2] - wstamp[1][b0+1], 4);

        // Early release: producer 0 gives 2 beats, producer 3 follows.
        do_reset();
        b0 = wcnt[0];
        b3 = wcnt[3];
        load(0, 8'h50, 2);
        load(3, 8'h80, 4);
        push(0, 8'h50); push(0, 8'h51);
        for (int k = 0; k < 4; k++) push(3, 8'h80 + k);
        release_rst();
        wait_drain("early_drain", 30);
        chk("early_gap", wstamp[3][b3] - wstamp[0][b0+1], 3);

        // Reset during beat 2 of producer 3, then 0 must win over 3.
        do_reset();
        load(3, 8'h90, 8);
        push(3, 8'h90); push(3, 8'h91);
        release_rst();
        found = 0;
        for (int n = 0; n < 20; n++) begin
            half_neg();
            if (s_wr && s_gid == 2'd3 && pidx[3] == 1) begin
                found = 1;
                break;
            end
            half_pos();
        end
        chk("midrst_beat2_seen", found, 1);
        #1 rst = 1'b0;
        #1;
        chk("midrst_fifo_wr", bus.fifo_wr, 0);
        chk("midrst_ready", bus.req_ready, 0);
        chk("midrst_grant_valid", bus.grant_valid, 0);
        do_reset();
        load(0, 8'hA0, 4);
        load(3, 8'hB0, 4);
        for (int k = 0; k < 4; k++) push(0, 8'hA0 + k);
        for (int k = 0; k < 4; k++) push(3, 8'hB0 + k);
        release_rst();
        wait_drain("midrst_drain", 40);

        step();
        step();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end
endmodule
